// File: rtl/bbox_overlay.sv
// Bounding-box overlay: measures the extent of mask pixels in each frame and draws
// that box on the next frame. Define BBOX_CROSS_EN to also draw the centre cross.
module bbox_overlay #(
  parameter logic [23:0] BOX_COLOR = 24'hFF0000,
  parameter int unsigned MIN_COUNT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pixel_in,
  input  logic        v_sync_in,
  input  logic        h_sync_in,
  input  logic        de_in,
  output logic [23:0] pixel_out,
  output logic        v_sync_out,
  output logic        h_sync_out,
  output logic        de_out
);

  localparam logic [10:0] COORD_MAX = 11'h7FF;
  localparam logic [21:0] CNT_MAX   = 22'h3FFFFF;
  localparam logic [21:0] MIN_CNT   = 22'(MIN_COUNT);

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == COORD_MAX) ? v : v + 11'd1;
  endfunction

  function automatic logic [21:0] sat_inc22(input logic [21:0] v);
    return (v == CNT_MAX) ? v : v + 22'd1;
  endfunction

  function automatic logic in_range(input logic [10:0] v, input logic [10:0] lo,
                                    input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic box_hit(input logic [10:0] cx, input logic [10:0] cy,
                                   input logic [10:0] x0, input logic [10:0] x1,
                                   input logic [10:0] y0, input logic [10:0] y1);
    return ((cx == x0 || cx == x1) && in_range(cy, y0, y1)) ||
           ((cy == y0 || cy == y1) && in_range(cx, x0, x1));
  endfunction

`ifdef BBOX_CROSS_EN
  function automatic logic [10:0] mid(input logic [10:0] a, input logic [10:0] b);
    logic [11:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[11:1];
  endfunction

  function automatic logic cross_hit(input logic [10:0] cx, input logic [10:0] cy,
                                     input logic [10:0] mx, input logic [10:0] my,
                                     input logic [10:0] x0, input logic [10:0] x1,
                                     input logic [10:0] y0, input logic [10:0] y1);
    return ((cx == mx) && in_range(cy, y0, y1)) ||
           ((cy == my) && in_range(cx, x0, x1));
  endfunction
`endif

  logic        v_sync_p0, h_sync_p0, de_p0;
  logic [23:0] pixel_p0;
  logic [10:0] x, y;
  logic [10:0] xmin, xmax, ymin, ymax;
  logic [21:0] cnt;
  logic [10:0] bx0, bx1, by0, by1;
  logic        box_valid;
  logic        vs_rise, de_fall, mask_hit, hit, paint;

  assign vs_rise  = v_sync_in & ~v_sync_p0;
  assign de_fall  = de_p0 & ~de_in;
  // A mask pixel landing on the frame-latch cycle belongs to neither frame.
  assign mask_hit = de_in & pixel_in[23] & ~vs_rise;

  // Coordinate counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= de_in ? sat_inc11(x) : 11'd0;
      if (vs_rise)
        y <= '0;
      else if (de_fall)
        y <= sat_inc11(y);
    end
  end

  // Per-frame accumulation and frame latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xmin      <= COORD_MAX;
      xmax      <= '0;
      ymin      <= COORD_MAX;
      ymax      <= '0;
      cnt       <= '0;
      bx0       <= '0;
      bx1       <= '0;
      by0       <= '0;
      by1       <= '0;
      box_valid <= 1'b0;
    end else if (vs_rise) begin
      bx0       <= xmin;
      bx1       <= xmax;
      by0       <= ymin;
      by1       <= ymax;
      box_valid <= (cnt >= MIN_CNT);
      xmin      <= COORD_MAX;
      xmax      <= '0;
      ymin      <= COORD_MAX;
      ymax      <= '0;
      cnt       <= '0;
    end else if (mask_hit) begin
      if (x < xmin) xmin <= x;
      if (x > xmax) xmax <= x;
      if (y < ymin) ymin <= y;
      if (y > ymax) ymax <= y;
      cnt <= sat_inc22(cnt);
    end
  end

`ifdef BBOX_CROSS_EN
  logic [10:0] cx, cy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx <= '0;
      cy <= '0;
    end else if (vs_rise) begin
      cx <= mid(xmin, xmax);
      cy <= mid(ymin, ymax);
    end
  end

  always_comb begin
    hit = box_hit(x, y, bx0, bx1, by0, by1) |
          cross_hit(x, y, cx, cy, bx0, bx1, by0, by1);
  end
`else
  always_comb begin
    hit = box_hit(x, y, bx0, bx1, by0, by1);
  end
`endif

  assign paint = box_valid & de_in & hit;

  // Output stage: one registered cycle for pixel and syncs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_p0  <= '0;
      v_sync_p0 <= 1'b0;
      h_sync_p0 <= 1'b0;
      de_p0     <= 1'b0;
    end else begin
      pixel_p0  <= paint ? BOX_COLOR : pixel_in;
      v_sync_p0 <= v_sync_in;
      h_sync_p0 <= h_sync_in;
      de_p0     <= de_in;
    end
  end

  assign pixel_out  = pixel_p0;
  assign v_sync_out = v_sync_p0;
  assign h_sync_out = h_sync_p0;
  assign de_out     = de_p0;

endmodule
